regfile_seq_ctrl: RTL

//  Multicycle sequencer for the 8x8 register file. Accepts one 16-bit instruction at a time over a

---
 rtl/regfile_seq_pkg.sv | 33 +++
 rtl/seq_instr_decode.sv | 30 +++
 rtl/regfile_seq_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM state
// encoding and instruction field positions.
package regfile_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_MOV  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RA_MSB  = 9;
  localparam int RA_LSB  = 7;
  localparam int RB_MSB  = 6;
  localparam int RB_LSB  = 4;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/seq_instr_decode.sv
// Combinational instruction field splitter and opcode classifier.
module seq_instr_decode
  import regfile_seq_pkg::*;
(
  input  logic [15:0] instr,
  output logic [2:0]  op,
  output logic [2:0]  rd,
  output logic [2:0]  ra,
  output logic [2:0]  rb,
  output logic [7:0]  imm,
  output logic        is_alu,
  output logic        is_ldi,
  output logic        is_nop,
  output logic        is_halt
);

  // Split fields and classify the opcode
  always_comb begin
    op      = instr[OP_MSB:OP_LSB];
    rd      = instr[RD_MSB:RD_LSB];
    ra      = instr[RA_MSB:RA_LSB];
    rb      = instr[RB_MSB:RB_LSB];
    imm     = instr[IMM_MSB:IMM_LSB];
    is_ldi  = (op == OP_LDI);
    is_nop  = (op == OP_NOP);
    is_halt = (op == OP_HALT);
    is_alu  = (op >= OP_MOV) && (op <= OP_OR);
  end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Multicycle sequencer driving the 8x8 register file selects, load enable,
// write-data mux and ALU opcode, one instruction at a time.
module regfile_seq_ctrl
  import regfile_seq_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [2:0]       sa,
  output logic [2:0]       sb,
  output logic [2:0]       s,
  output logic             L,
  output logic [2:0]       alu_op,
  output logic             ip_sel,
  output logic [7:0]       imm,
  output logic             busy,
  output logic             halted,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_cnt
);

  // Counter wide enough for ALU_LAT-1 up to 3
  localparam int              EXEC_W    = 3;
  localparam logic [EXEC_W-1:0] EXEC_LOAD = EXEC_W'(ALU_LAT - 1);

  state_t              state, state_nxt;
  logic [15:0]         instr_p0;
  logic [EXEC_W-1:0]   exec_cnt;
  logic [CNT_W-1:0]    cnt_q;
  logic                ready_i;
  logic                retire;
  logic                write_en;
  logic                active;
  logic                accept;

  logic [2:0] d_op, d_rd, d_ra, d_rb;
  logic [7:0] d_imm;
  logic       d_is_alu, d_is_ldi, d_is_nop, d_is_halt;

  seq_instr_decode u_decode (
    .instr   (instr_p0),
    .op      (d_op),
    .rd      (d_rd),
    .ra      (d_ra),
    .rb      (d_rb),
    .imm     (d_imm),
    .is_alu  (d_is_alu),
    .is_ldi  (d_is_ldi),
    .is_nop  (d_is_nop),
    .is_halt (d_is_halt)
  );

  assign accept = instr_valid && instr_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus internal retire/write strobes
  always_comb begin
    state_nxt = state;
    ready_i   = 1'b0;
    retire    = 1'b0;
    write_en  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready_i = 1'b1;
        if (instr_valid) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (d_is_ldi) begin
          state_nxt = ST_WB;
        end else if (d_is_alu) begin
          state_nxt = ST_EXEC;
        end else if (d_is_halt) begin
          retire    = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          retire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (exec_cnt == '0) state_nxt = ST_WB;
      end
      ST_WB: begin
        write_en  = 1'b1;
        retire    = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Instruction latch, captured only on a handshake
  always_ff @(posedge clk) begin
    if (rst)         instr_p0 <= '0;
    else if (accept) instr_p0 <= instr;
  end

  // EXEC down-counter: loaded in DECODE, EXEC ends when it reaches zero
  always_ff @(posedge clk) begin
    if (rst)                                     exec_cnt <= '0;
    else if (state == ST_DECODE)                 exec_cnt <= EXEC_LOAD;
    else if (state == ST_EXEC && exec_cnt != '0) exec_cnt <= exec_cnt - 1'b1;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 1'b1;
  end

  // Output decode; everything forced low while rst is high so no write lands on a reset edge
  always_comb begin
    active      = (state == ST_DECODE) || (state == ST_EXEC) || (state == ST_WB);
    instr_ready = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    instr_done  = 1'b0;
    L           = 1'b0;
    s           = '0;
    ip_sel      = 1'b0;
    sa          = '0;
    sb          = '0;
    alu_op      = '0;
    imm         = '0;
    retired_cnt = '0;
    if (!rst) begin
      instr_ready = ready_i;
      busy        = active;
      halted      = (state == ST_HALT);
      instr_done  = retire;
      L           = write_en;
      s           = write_en ? d_rd : 3'd0;
      ip_sel      = write_en && d_is_ldi;
      retired_cnt = cnt_q;
      if (active) begin
        sa     = d_ra;
        sb     = d_rb;
        alu_op = d_op;
        imm    = d_is_ldi ? d_imm : 8'd0;
      end
    end
  end

endmodule
